tlb_op_ctrl: RTL and testbench

Sequencer for the TLB-management instructions (TLBP, TLBR, TLBWI, TLBWR) between the CP0 register file and the TLB array.
- Accepts one op at a time and latches its CP0 operands.
- Drives the TLB search port 1, write port and read port.
- Returns a one-cycle result pulse that CP0 uses to update Index/EntryHi/EntryLo0/EntryLo1.
- Search port 0 (fetch) is untouched; integration ties s1_odd_page to 0.

---
 rtl/tlb_op_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR between the CP0 register file and the TLB array.
// Optional macro TLB_RANDOM_EN enables the free-running Random register used by TLBWR.
module tlb_op_ctrl #(
    parameter int  TLBNUM = 8,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          op_valid,
    input  logic [1:0]    op_code,
    output logic          op_ready,

    input  logic [31:0]   cp0_entryhi,
    input  logic [31:0]   cp0_entrylo0,
    input  logic [31:0]   cp0_entrylo1,
    input  logic [IW-1:0] cp0_index,
    output logic [IW-1:0] random,

    output logic [18:0]   tlb_s_vpn2,
    output logic [7:0]    tlb_s_asid,
    input  logic          tlb_s_found,
    input  logic [IW-1:0] tlb_s_index,

    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic [18:0]   tlb_w_vpn2,
    output logic [7:0]    tlb_w_asid,
    output logic          tlb_w_g,
    output logic [24:0]   tlb_w_lo0,
    output logic [24:0]   tlb_w_lo1,

    output logic [IW-1:0] tlb_r_index,
    input  logic [18:0]   tlb_r_vpn2,
    input  logic [7:0]    tlb_r_asid,
    input  logic          tlb_r_g,
    input  logic [24:0]   tlb_r_lo0,
    input  logic [24:0]   tlb_r_lo1,

    output logic          done,
    output logic          res_probe_miss,
    output logic [IW-1:0] res_index,
    output logic [31:0]   res_entryhi,
    output logic [31:0]   res_entrylo0,
    output logic [31:0]   res_entrylo1
);

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWI = 2'd2;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic [IW-1:0] target_idx;

    logic [1:0]    op_q;
    logic [18:0]   vpn2_q;
    logic [7:0]    asid_q;
    logic [25:0]   lo0_q;
    logic [25:0]   lo1_q;
    logic [IW-1:0] idx_q;

    logic          unused_bits;

    assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

    // Random counts down every cycle so TLBWR picks a pseudo-random victim.
`ifdef TLB_RANDOM_EN
    logic [IW-1:0] random_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            random_q <= IW'(TLBNUM - 1);
        end else if (random_q == '0) begin
            random_q <= IW'(TLBNUM - 1);
        end else begin
            random_q <= random_q - IW'(1);
        end
    end

    assign random     = random_q;
    assign target_idx = (op_code == OP_TLBWR) ? random_q : cp0_index;
`else
    assign random     = '0;
    assign target_idx = cp0_index;
`endif

    assign op_ready = (state_q == IDLE);
    assign accept   = op_valid && op_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are frozen at accept so CP0 may change while the op is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= OP_TLBP;
            vpn2_q <= '0;
            asid_q <= '0;
            lo0_q  <= '0;
            lo1_q  <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            op_q   <= op_code;
            vpn2_q <= cp0_entryhi[31:13];
            asid_q <= cp0_entryhi[7:0];
            lo0_q  <= cp0_entrylo0[25:0];
            lo1_q  <= cp0_entrylo1[25:0];
            idx_q  <= target_idx;
        end
    end

    assign tlb_s_vpn2  = vpn2_q;
    assign tlb_s_asid  = asid_q;

    assign tlb_we      = (state_q == EXEC) && ((op_q == OP_TLBWI) || (op_q == OP_TLBWR));
    assign tlb_w_index = idx_q;
    assign tlb_w_vpn2  = vpn2_q;
    assign tlb_w_asid  = asid_q;
    assign tlb_w_g     = lo0_q[0] & lo1_q[0];
    assign tlb_w_lo0   = lo0_q[25:1];
    assign tlb_w_lo1   = lo1_q[25:1];

    assign tlb_r_index = idx_q;

    assign done        = (state_q == RESP);

    // Results become visible in RESP and hold until the next op of the same kind.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_probe_miss <= 1'b0;
            res_index      <= '0;
            res_entryhi    <= '0;
            res_entrylo0   <= '0;
            res_entrylo1   <= '0;
        end else if (state_q == EXEC) begin
            case (op_q)
                OP_TLBP: begin
                    res_probe_miss <= ~tlb_s_found;
                    res_index      <= tlb_s_found ? tlb_s_index : '0;
                end
                OP_TLBR: begin
                    res_entryhi  <= {tlb_r_vpn2, 5'b0, tlb_r_asid};
                    res_entrylo0 <= {6'b0, tlb_r_lo0, tlb_r_g};
                    res_entrylo1 <= {6'b0, tlb_r_lo1, tlb_r_g};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed scoreboard bench for tlb_op_ctrl with a small behavioural TLB array.
module tb_tlb_op_ctrl;

    localparam int IW = 3;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWI = 2'd2;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    logic          clk;
    logic          reset;
    logic          op_valid;
    logic [1:0]    op_code;
    logic          op_ready;
    logic [31:0]   cp0_entryhi;
    logic [31:0]   cp0_entrylo0;
    logic [31:0]   cp0_entrylo1;
    logic [IW-1:0] cp0_index;
    logic [IW-1:0] random;
    logic [18:0]   tlb_s_vpn2;
    logic [7:0]    tlb_s_asid;
    logic          s_found;
    logic [IW-1:0] s_index;
    logic          tlb_we;
    logic [IW-1:0] tlb_w_index;
    logic [18:0]   tlb_w_vpn2;
    logic [7:0]    tlb_w_asid;
    logic          tlb_w_g;
    logic [24:0]   tlb_w_lo0;
    logic [24:0]   tlb_w_lo1;
    logic [IW-1:0] tlb_r_index;
    logic          done;
    logic          res_probe_miss;
    logic [IW-1:0] res_index;
    logic [31:0]   res_entryhi;
    logic [31:0]   res_entrylo0;
    logic [31:0]   res_entrylo1;

    logic [18:0] t_vpn2 [8];
    logic [7:0]  t_asid [8];
    logic        t_g    [8];
    logic [24:0] t_lo0  [8];
    logic [24:0] t_lo1  [8];

    tlb_op_ctrl #(.TLBNUM(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .op_valid       (op_valid),
        .op_code        (op_code),
        .op_ready       (op_ready),
        .cp0_entryhi    (cp0_entryhi),
        .cp0_entrylo0   (cp0_entrylo0),
        .cp0_entrylo1   (cp0_entrylo1),
        .cp0_index      (cp0_index),
        .random         (random),
        .tlb_s_vpn2     (tlb_s_vpn2),
        .tlb_s_asid     (tlb_s_asid),
        .tlb_s_found    (s_found),
        .tlb_s_index    (s_index),
        .tlb_we         (tlb_we),
        .tlb_w_index    (tlb_w_index),
        .tlb_w_vpn2     (tlb_w_vpn2),
        .tlb_w_asid     (tlb_w_asid),
        .tlb_w_g        (tlb_w_g),
        .tlb_w_lo0      (tlb_w_lo0),
        .tlb_w_lo1      (tlb_w_lo1),
        .tlb_r_index    (tlb_r_index),
        .tlb_r_vpn2     (t_vpn2[tlb_r_index]),
        .tlb_r_asid     (t_asid[tlb_r_index]),
        .tlb_r_g        (t_g[tlb_r_index]),
        .tlb_r_lo0      (t_lo0[tlb_r_index]),
        .tlb_r_lo1      (t_lo1[tlb_r_index]),
        .done           (done),
        .res_probe_miss (res_probe_miss),
        .res_index      (res_index),
        .res_entryhi    (res_entryhi),
        .res_entrylo0   (res_entrylo0),
        .res_entrylo1   (res_entrylo1)
    );

    typedef struct {
        int          cyc;
        logic        miss;
        logic [2:0]  idx;
        logic [31:0] ehi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } res_t;

    typedef struct {
        int          cyc;
        logic [2:0]  idx;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [24:0] lo0;
        logic [24:0] lo1;
    } wr_t;

    res_t res_q[$];
    wr_t  wr_q[$];
    res_t mon_r;
    wr_t  mon_w;
    logic exp_done;
    logic exp_we;

    int   cyc = 0;
    int   n_asserts = 0;
    int   n_fails = 0;

    logic        m_miss;
    logic [2:0]  m_idx;
    logic [31:0] m_ehi;
    logic [31:0] m_lo0;
    logic [31:0] m_lo1;
    logic [2:0]  wr_idx;
    logic [2:0]  exp_rand;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) exp_rand <= 3'd7;
        else       exp_rand <= (exp_rand == 3'd0) ? 3'd7 : exp_rand - 3'd1;
    end

    // Behavioural TLB: cleared on reset to distinct non-matching entries.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                t_vpn2[i] <= 19'h40000 + 19'(i);
                t_asid[i] <= 8'hFF;
                t_g[i]    <= 1'b0;
                t_lo0[i]  <= '0;
                t_lo1[i]  <= '0;
            end
        end else if (tlb_we) begin
            t_vpn2[tlb_w_index] <= tlb_w_vpn2;
            t_asid[tlb_w_index] <= tlb_w_asid;
            t_g[tlb_w_index]    <= tlb_w_g;
            t_lo0[tlb_w_index]  <= tlb_w_lo0;
            t_lo1[tlb_w_index]  <= tlb_w_lo1;
        end
    end

    always_comb begin
        s_found = 1'b0;
        s_index = '0;
        for (int i = 0; i < 8; i++) begin
            if (t_vpn2[i] == tlb_s_vpn2 && (t_g[i] || t_asid[i] == tlb_s_asid)) begin
                s_found = 1'b1;
                s_index = 3'(i);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic pushRes(input int at);
        res_t r;
        r.cyc  = at + 2;
        r.miss = m_miss;
        r.idx  = m_idx;
        r.ehi  = m_ehi;
        r.lo0  = m_lo0;
        r.lo1  = m_lo1;
        res_q.push_back(r);
    endtask

    task automatic expectProbe(input int at, input logic miss, input logic [2:0] idx);
        m_miss = miss;
        m_idx  = idx;
        pushRes(at);
    endtask

    task automatic expectRead(input int at, input logic [31:0] ehi, input logic [31:0] lo0, input logic [31:0] lo1);
        m_ehi = ehi;
        m_lo0 = lo0;
        m_lo1 = lo1;
        pushRes(at);
    endtask

    task automatic expectWrite(input int at, input logic [2:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                               input logic g, input logic [24:0] lo0, input logic [24:0] lo1);
        wr_t w;
        w.cyc  = at + 1;
        w.idx  = idx;
        w.vpn2 = vpn2;
        w.asid = asid;
        w.g    = g;
        w.lo0  = lo0;
        w.lo1  = lo1;
        wr_q.push_back(w);
        pushRes(at);
    endtask

    // Drives one op from a negedge, then scrambles CP0 inputs to prove they were latched.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] ehi, input logic [31:0] lo0,
                                 input logic [31:0] lo1, input logic [2:0] idx);
        checkOutput("op_ready_idle", 32'(op_ready), 32'd1);
        op_valid     = 1'b1;
        op_code      = op;
        cp0_entryhi  = ehi;
        cp0_entrylo0 = lo0;
        cp0_entrylo1 = lo1;
        cp0_index    = idx;
        @(posedge clk);
        #1;
        op_valid     = 1'b0;
        op_code      = 2'($urandom);
        cp0_entryhi  = $urandom;
        cp0_entrylo0 = $urandom;
        cp0_entrylo1 = $urandom;
        cp0_index    = 3'($urandom);
        @(negedge clk);
        checkOutput("op_ready_busy", 32'(op_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_done = (res_q.size() != 0) && (res_q[0].cyc <= cyc);
        checkOutput("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
            mon_r = res_q.pop_front();
            checkOutput("res_probe_miss", 32'(res_probe_miss), 32'(mon_r.miss));
            checkOutput("res_index", 32'(res_index), 32'(mon_r.idx));
            checkOutput("res_entryhi", res_entryhi, mon_r.ehi);
            checkOutput("res_entrylo0", res_entrylo0, mon_r.lo0);
            checkOutput("res_entrylo1", res_entrylo1, mon_r.lo1);
        end
        exp_we = (wr_q.size() != 0) && (wr_q[0].cyc <= cyc);
        checkOutput("tlb_we", 32'(tlb_we), 32'(exp_we));
        if (exp_we) begin
            mon_w = wr_q.pop_front();
            checkOutput("w_index", 32'(tlb_w_index), 32'(mon_w.idx));
            checkOutput("w_vpn2", 32'(tlb_w_vpn2), 32'(mon_w.vpn2));
            checkOutput("w_asid", 32'(tlb_w_asid), 32'(mon_w.asid));
            checkOutput("w_g", 32'(tlb_w_g), 32'(mon_w.g));
            checkOutput("w_lo0", 32'(tlb_w_lo0), 32'(mon_w.lo0));
            checkOutput("w_lo1", 32'(tlb_w_lo1), 32'(mon_w.lo1));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_r;
        reset        = 1'b1;
        op_valid     = 1'b0;
        op_code      = '0;
        cp0_entryhi  = '0;
        cp0_entrylo0 = '0;
        cp0_entrylo1 = '0;
        cp0_index    = '0;
        m_miss = 1'b0; m_idx = '0; m_ehi = '0; m_lo0 = '0; m_lo1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        checkOutput("rst_op_ready", 32'(op_ready), 32'd1);
        checkOutput("rst_res_miss", 32'(res_probe_miss), 32'd0);
        checkOutput("rst_res_index", 32'(res_index), 32'd0);
        checkOutput("rst_res_entryhi", res_entryhi, 32'd0);
        checkOutput("rst_res_entrylo0", res_entrylo0, 32'd0);
        checkOutput("rst_res_entrylo1", res_entrylo1, 32'd0);

        for (int i = 0; i < 9; i++) begin
`ifdef TLB_RANDOM_EN
            exp_r = (7 - i) & 7;
`else
            exp_r = 0;
`endif
            checkOutput("random_seq", 32'(random), 32'(exp_r));
            checkOutput("idle_op_ready", 32'(op_ready), 32'd1);
            @(negedge clk);
        end

        $display("[TB] TLBWI index 3");
        expectWrite(cyc, 3'd3, 19'h5, 8'h12, 1'b1, 25'h23, 25'h43);
        applyStimulus(OP_TLBWI, 32'h0000A012, 32'h00000047, 32'h00000087, 3'd3);

        $display("[TB] TLBP hit and miss");
        expectProbe(cyc, 1'b0, 3'd3);
        applyStimulus(OP_TLBP, 32'h0000A034, 32'h0, 32'h0, 3'd0);
        expectProbe(cyc, 1'b1, 3'd0);
        applyStimulus(OP_TLBP, 32'h0000C034, 32'h0, 32'h0, 3'd3);

        $display("[TB] TLBR index 3");
        expectRead(cyc, 32'h0000A012, 32'h00000047, 32'h00000087);
        applyStimulus(OP_TLBR, 32'h0, 32'h0, 32'h0, 3'd3);

        $display("[TB] TLBWR");
`ifdef TLB_RANDOM_EN
        wr_idx = 3'd5;
        for (int i = 0; i < 16 && exp_rand != 3'd5; i++) @(negedge clk);
        checkOutput("random_at_wr", 32'(random), 32'd5);
`else
        wr_idx = 3'd2;
        checkOutput("random_const", 32'(random), 32'd0);
`endif
        expectWrite(cyc, wr_idx, 19'h7, 8'h56, 1'b0, 25'h91A, 25'h2B3C);
        applyStimulus(OP_TLBWR, 32'h0000E056, 32'h00001234, 32'h00005679, 3'd2);
        expectRead(cyc, 32'h0000E056, 32'h00001234, 32'h00005678);
        applyStimulus(OP_TLBR, 32'h0, 32'h0, 32'h0, wr_idx);

        $display("[TB] back-to-back TLBP with op_valid held");
        expectProbe(cyc, 1'b0, 3'd3);
        expectProbe(cyc + 3, 1'b0, 3'd3);
        expectProbe(cyc + 6, 1'b0, 3'd3);
        op_valid     = 1'b1;
        op_code      = OP_TLBP;
        cp0_entryhi  = 32'h0000A034;
        for (int i = 0; i < 7; i++) begin
            checkOutput("b2b_op_ready", 32'(op_ready), 32'((i % 3) == 0));
            @(negedge clk);
        end
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("b2b_end_ready", 32'(op_ready), 32'd1);

        $display("[TB] reset during TLBP EXEC");
        checkOutput("op_ready_idle", 32'(op_ready), 32'd1);
        op_valid    = 1'b1;
        op_code     = OP_TLBP;
        cp0_entryhi = 32'h0000C034;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        reset    = 1'b1;
        m_miss = 1'b0; m_idx = '0; m_ehi = '0; m_lo0 = '0; m_lo1 = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_op_ready", 32'(op_ready), 32'd1);
        checkOutput("abort_res_miss", 32'(res_probe_miss), 32'd0);
        checkOutput("abort_res_index", 32'(res_index), 32'd0);
        checkOutput("abort_res_entryhi", res_entryhi, 32'd0);
        checkOutput("abort_res_entrylo0", res_entrylo0, 32'd0);
        checkOutput("abort_res_entrylo1", res_entrylo1, 32'd0);
`ifdef TLB_RANDOM_EN
        checkOutput("abort_random", 32'(random), 32'd7);
`else
        checkOutput("abort_random", 32'(random), 32'd0);
`endif
        repeat (4) @(negedge clk);
        checkOutput("sb_res_empty", 32'(res_q.size()), 32'd0);
        checkOutput("sb_wr_empty", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
